// File: rtl/adaptive_pkg.sv
// Shared types and default parameters for the adaptive control unit's mode governor.
// The optional GOVERNOR_FORCE_EN build of the governor adds a software mode override.
package adaptive_pkg;

    typedef enum logic {
        MODE_LP = 1'b0,
        MODE_HP = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        S_LP,
        S_TO_HP,
        S_HP,
        S_TO_LP
    } gov_state_e;

    localparam int unsigned DEF_WINDOW_LEN    = 16;
    localparam int unsigned DEF_HI_THRESH     = 12;
    localparam int unsigned DEF_LO_THRESH     = 4;
    localparam int unsigned DEF_SETTLE_CYCLES = 2;

    function automatic logic is_settling(input gov_state_e s);
        return (s == S_TO_HP) || (s == S_TO_LP);
    endfunction

endpackage

// File: rtl/activity_window_counter.sv
// Counts valid strobes over back-to-back fixed windows and publishes each window's total.
// close/final_count expose the closing cycle combinationally so the FSM decides on the same edge.
module activity_window_counter
    import adaptive_pkg::*;
#(
    parameter int unsigned WINDOW_LEN = DEF_WINDOW_LEN,
    localparam int unsigned WW = $clog2(WINDOW_LEN),
    localparam int unsigned CW = $clog2(WINDOW_LEN) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid,
    output logic          close,
    output logic [CW-1:0] final_count,
    output logic          window_done,
    output logic [CW-1:0] activity_count
);

    logic [WW-1:0] wcnt;
    logic [CW-1:0] act_cnt;

    assign close       = (wcnt == WW'(WINDOW_LEN - 1));
    // CW bits hold WINDOW_LEN exactly, so a window of all-valid cycles cannot overflow.
    assign final_count = act_cnt + CW'(valid);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt           <= '0;
            act_cnt        <= '0;
            window_done    <= 1'b0;
            activity_count <= '0;
        end else begin
            wcnt <= close ? '0 : wcnt + 1'b1;
            if (close) begin
                act_cnt        <= '0;
                activity_count <= final_count;
                window_done    <= 1'b1;
            end else begin
                act_cnt     <= final_count;
                window_done <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/adaptive_mode_governor.sv
// Hysteresis governor choosing Low-Power / High-Performance mode from windowed valid activity.
// Define GOVERNOR_FORCE_EN to add force_en/force_mode override ports.
module adaptive_mode_governor
    import adaptive_pkg::*;
#(
    parameter int unsigned WINDOW_LEN    = DEF_WINDOW_LEN,
    parameter int unsigned HI_THRESH     = DEF_HI_THRESH,
    parameter int unsigned LO_THRESH     = DEF_LO_THRESH,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    localparam int unsigned CW = $clog2(WINDOW_LEN) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid,
`ifdef GOVERNOR_FORCE_EN
    input  logic          force_en,
    input  logic          force_mode,
`endif
    output logic          mode,
    output logic          switching,
    output logic          mode_switch,
    output logic          window_done,
    output logic [CW-1:0] activity_count
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

    logic          close;
    logic [CW-1:0] final_count;

    gov_state_e    state, state_next;
    logic [SW-1:0] settle_cnt, settle_next;
    mode_e         mode_q, mode_next;
    logic          mode_switch_next;
    logic          hp_req, lp_req;

    activity_window_counter #(
        .WINDOW_LEN (WINDOW_LEN)
    ) u_window (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid          (valid),
        .close          (close),
        .final_count    (final_count),
        .window_done    (window_done),
        .activity_count (activity_count)
    );

    // Requests are only acted on from the steady states, so evaluations mid-settle fall away.
    always_comb begin
        hp_req = close && (final_count >= CW'(HI_THRESH));
        lp_req = close && (final_count <= CW'(LO_THRESH));
`ifdef GOVERNOR_FORCE_EN
        if (force_en) begin
            hp_req = (force_mode == MODE_HP);
            lp_req = (force_mode == MODE_LP);
        end
`endif
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next       = state;
        settle_next      = settle_cnt;
        mode_next        = mode_q;
        mode_switch_next = 1'b0;
        case (state)
            S_LP: begin
                if (hp_req) begin
                    state_next  = S_TO_HP;
                    settle_next = SW'(SETTLE_CYCLES);
                end
            end
            S_TO_HP: begin
                if (settle_cnt == SW'(1)) begin
                    state_next       = S_HP;
                    mode_next        = MODE_HP;
                    mode_switch_next = 1'b1;
                end else begin
                    settle_next = settle_cnt - 1'b1;
                end
            end
            S_HP: begin
                if (lp_req) begin
                    state_next  = S_TO_LP;
                    settle_next = SW'(SETTLE_CYCLES);
                end
            end
            S_TO_LP: begin
                if (settle_cnt == SW'(1)) begin
                    state_next       = S_LP;
                    mode_next        = MODE_LP;
                    mode_switch_next = 1'b1;
                end else begin
                    settle_next = settle_cnt - 1'b1;
                end
            end
            default: begin
                state_next = S_LP;
                mode_next  = MODE_LP;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_LP;
            settle_cnt  <= '0;
            mode_q      <= MODE_LP;
            mode_switch <= 1'b0;
        end else begin
            state       <= state_next;
            settle_cnt  <= settle_next;
            mode_q      <= mode_next;
            mode_switch <= mode_switch_next;
        end
    end

    assign mode      = mode_q;
    assign switching = is_settling(state);

endmodule

// File: tb/tb_adaptive_mode_governor.sv
// Directed bench for adaptive_mode_governor: window table plus reset, settle and force sequences.
module tb_adaptive_mode_governor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic       force_en = 1'b0;
    logic       force_mode = 1'b0;
    logic       mode;
    logic       switching;
    logic       mode_switch;
    logic       window_done;
    logic [4:0] activity_count;

    int total = 0;
    int bad = 0;

    int early_done;
    int sw_cnt;
    int pulse_cnt;
    int mode0_cnt;

    typedef struct {
        int   nv;
        int   cnt;
        logic sw_close;
        logic mode_close;
        int   sw_cycles;
        int   pulses;
    } win_vec_t;

    win_vec_t vec[13];

    always #5 clk = ~clk;

    adaptive_mode_governor dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid          (valid),
`ifdef GOVERNOR_FORCE_EN
        .force_en       (force_en),
        .force_mode     (force_mode),
`endif
        .mode           (mode),
        .switching      (switching),
        .mode_switch    (mode_switch),
        .window_done    (window_done),
        .activity_count (activity_count)
    );

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One full window: valid high for the first nv cycles, outputs sampled after every edge.
    task automatic run_window(input int nv);
        early_done = 0;
        sw_cnt     = 0;
        pulse_cnt  = 0;
        mode0_cnt  = 0;
        for (int c = 0; c < 16; c++) begin
            valid = (c < nv);
            step();
            if (c < 15 && window_done) early_done++;
            if (switching) sw_cnt++;
            if (mode_switch) pulse_cnt++;
            if (!mode) mode0_cnt++;
        end
    endtask

    initial begin
        // nv, count, switching@close, mode@close, switching cycles, mode_switch pulses
        vec[0]  = '{0,  0,  1'b0, 1'b0, 0, 0};
        vec[1]  = '{0,  0,  1'b0, 1'b0, 0, 0};
        vec[2]  = '{0,  0,  1'b0, 1'b0, 0, 0};
        vec[3]  = '{0,  0,  1'b0, 1'b0, 0, 0};
        vec[4]  = '{11, 11, 1'b0, 1'b0, 0, 0};
        vec[5]  = '{12, 12, 1'b1, 1'b0, 1, 0};
        vec[6]  = '{8,  8,  1'b0, 1'b1, 1, 1};
        vec[7]  = '{5,  5,  1'b0, 1'b1, 0, 0};
        vec[8]  = '{4,  4,  1'b1, 1'b1, 1, 0};
        vec[9]  = '{16, 16, 1'b1, 1'b0, 2, 1};
        vec[10] = '{16, 16, 1'b0, 1'b1, 1, 1};
        vec[11] = '{12, 12, 1'b0, 1'b1, 0, 0};
        vec[12] = '{5,  5,  1'b0, 1'b1, 0, 0};

        do_reset();
        check("reset mode", mode, 0);
        check("reset switching", switching, 0);
        check("reset mode_switch", mode_switch, 0);
        check("reset window_done", window_done, 0);
        check("reset activity_count", activity_count, 0);

        for (int i = 0; i < 13; i++) begin
            run_window(vec[i].nv);
            check($sformatf("w%0d early window_done", i), early_done, 0);
            check($sformatf("w%0d window_done", i), window_done, 1);
            check($sformatf("w%0d activity_count", i), activity_count, vec[i].cnt);
            check($sformatf("w%0d switching at close", i), switching, vec[i].sw_close);
            check($sformatf("w%0d mode at close", i), mode, vec[i].mode_close);
            check($sformatf("w%0d switching cycles", i), sw_cnt, vec[i].sw_cycles);
            check($sformatf("w%0d mode_switch pulses", i), pulse_cnt, vec[i].pulses);
        end

        // Continuous activity from reset: full window, two settle cycles, then HP.
        do_reset();
        run_window(16);
        check("cont window_done", window_done, 1);
        check("cont activity_count", activity_count, 16);
        check("cont switching at close", switching, 1);
        check("cont mode at close", mode, 0);
        valid = 1'b1;
        step();
        check("cont settle2 switching", switching, 1);
        check("cont settle2 mode", mode, 0);
        check("cont settle2 mode_switch", mode_switch, 0);
        step();
        check("cont exit mode", mode, 1);
        check("cont exit mode_switch", mode_switch, 1);
        check("cont exit switching", switching, 0);
        step();
        check("cont after pulse mode_switch", mode_switch, 0);
        check("cont after pulse mode", mode, 1);

        // Reset mid-settle must clear outputs without a clock edge.
        do_reset();
        run_window(16);
        check("pre-abort switching", switching, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort switching", switching, 0);
        check("abort mode", mode, 0);
        check("abort activity_count", activity_count, 0);
        check("abort window_done", window_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_window(16);
        check("restart early window_done", early_done, 0);
        check("restart window_done", window_done, 1);
        check("restart activity_count", activity_count, 16);
        check("restart switching", switching, 1);
        valid = 1'b0;
        repeat (2) step();
        check("restart reached HP", mode, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset from HP mode", mode, 0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef GOVERNOR_FORCE_EN
        rst_n      = 1'b0;
        force_en   = 1'b1;
        force_mode = 1'b1;
        do_reset();
        valid = 1'b0;
        step();
        check("force settle1 switching", switching, 1);
        check("force settle1 mode", mode, 0);
        step();
        check("force settle2 switching", switching, 1);
        step();
        check("force exit mode", mode, 1);
        check("force exit mode_switch", mode_switch, 1);
        check("force exit switching", switching, 0);
        mode0_cnt = 0;
        sw_cnt    = 0;
        for (int c = 3; c < 48; c++) begin
            step();
            if (!mode) mode0_cnt++;
            if (switching) sw_cnt++;
        end
        check("force hold mode0 cycles", mode0_cnt, 0);
        check("force hold switching cycles", sw_cnt, 0);
        force_en = 1'b0;
        run_window(0);
        check("release window_done", window_done, 1);
        check("release switching at close", switching, 1);
        check("release mode at close", mode, 1);
        step();
        check("release settle2 switching", switching, 1);
        step();
        check("release exit mode", mode, 0);
        check("release exit mode_switch", mode_switch, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
